// File: rtl/sha256_iter_core.sv
// rtl/sha256_iter_core.sv - iterative SHA-256 compression core with per-job double hash
// Purpose : folds the 64 SHA-256 rounds onto UNROLL combinational round stages that are
//           reused for 64/UNROLL cycles. When in_dbl is set, the first digest is hashed
//           again as a padded 32-byte message (SHA-256d).
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready   job handshake; in_state (word i at [32i+31:32i], word 0 = a),
//                               in_block (W0 at [31:0]), in_dbl
//           out_valid/out_ready hash handshake; out_hash (same packing as in_state)
//           busy                FSM not idle
// Option  : SHA256_TARGET_CMP_EN adds input target[255:0] and output out_hit
//           (byte-reversed out_hash <= target, unsigned, registered with out_hash).
module sha256_iter_core #(
  parameter int           UNROLL = 4,
  parameter logic [255:0] IV     = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_state,
  input  logic [511:0] in_block,
  input  logic         in_dbl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_hash,
`ifdef SHA256_TARGET_CMP_EN
  input  logic [255:0] target,
  output logic         out_hit,
`endif
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 &&
      UNROLL != 16 && UNROLL != 32 && UNROLL != 64) begin : g_bad_unroll
    $error("sha256_iter_core: UNROLL must be 1, 2, 4, 8, 16, 32 or 64");
  end

  localparam logic [5:0] CNT_LAST = 6'(64 / UNROLL - 1);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {S_IDLE, S_RUN1, S_ADD1, S_RUN2, S_ADD2, S_DONE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t       r_state, w_next;
  logic [31:0]  r_v [8];   // working variables a..h
  logic [31:0]  r_h [8];   // chaining value added back in ADD1/ADD2
  logic [31:0]  r_w [16];  // message schedule window, r_w[0] = W for the next round
  logic [5:0]   r_cnt;
  logic         r_dbl;
  logic [255:0] r_hash;

  logic [31:0]  w_v [8];
  logic [31:0]  w_w [16];
  logic [31:0]  w_t1, w_t2, w_wn;
  logic [5:0]   w_kidx;
  logic [255:0] w_sum;
  logic         w_fin;     // final digest is produced this cycle

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_hash  = r_hash;
  assign w_fin     = (r_state == S_ADD2) || (r_state == S_ADD1 && !r_dbl);

  // UNROLL chained rounds; the schedule window slides one word per round.
  always_comb begin
    w_t1   = '0;
    w_t2   = '0;
    w_wn   = '0;
    w_kidx = '0;
    for (int i = 0; i < 8; i++)  w_v[i] = r_v[i];
    for (int i = 0; i < 16; i++) w_w[i] = r_w[i];
    for (int j = 0; j < UNROLL; j++) begin
      w_kidx = 6'(32'(r_cnt) * 32'(UNROLL) + 32'(j));
      w_t1 = w_v[7] + bsig1(w_v[4]) + ((w_v[4] & w_v[5]) ^ (~w_v[4] & w_v[6])) + K[w_kidx] + w_w[0];
      w_t2 = bsig0(w_v[0]) + ((w_v[0] & w_v[1]) ^ (w_v[0] & w_v[2]) ^ (w_v[1] & w_v[2]));
      w_wn = ssig1(w_w[14]) + w_w[9] + ssig0(w_w[1]) + w_w[0];
      for (int i = 7; i > 0; i--) w_v[i] = w_v[i-1];
      w_v[4] = w_v[4] + w_t1;
      w_v[0] = w_t1 + w_t2;
      for (int i = 0; i < 15; i++) w_w[i] = w_w[i+1];
      w_w[15] = w_wn;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++) w_sum[32*i +: 32] = r_h[i] + r_v[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)             w_next = S_RUN1;
      S_RUN1:  if (r_cnt == CNT_LAST)    w_next = S_ADD1;
      S_ADD1:  w_next = r_dbl ? S_RUN2 : S_DONE;
      S_RUN2:  if (r_cnt == CNT_LAST)    w_next = S_ADD2;
      S_ADD2:  w_next = S_DONE;
      S_DONE:  if (out_ready)            w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_v[i] <= '0;
        r_h[i] <= '0;
      end
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      r_cnt  <= '0;
      r_dbl  <= 1'b0;
      r_hash <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          for (int i = 0; i < 8; i++) begin
            r_h[i] <= in_state[32*i +: 32];
            r_v[i] <= in_state[32*i +: 32];
          end
          for (int i = 0; i < 16; i++) r_w[i] <= in_block[32*i +: 32];
          r_dbl <= in_dbl;
          r_cnt <= '0;
        end
        S_RUN1, S_RUN2: begin
          for (int i = 0; i < 8; i++)  r_v[i] <= w_v[i];
          for (int i = 0; i < 16; i++) r_w[i] <= w_w[i];
          r_cnt <= (r_cnt == CNT_LAST) ? 6'd0 : r_cnt + 6'd1;
        end
        S_ADD1: if (r_dbl) begin
          // Second pass hashes the 32-byte digest: one padded block, length 256 bits.
          for (int i = 0; i < 8; i++) begin
            r_h[i] <= IV[32*i +: 32];
            r_v[i] <= IV[32*i +: 32];
            r_w[i] <= w_sum[32*i +: 32];
          end
          r_w[8] <= 32'h80000000;
          for (int i = 9; i < 15; i++) r_w[i] <= '0;
          r_w[15] <= 32'h00000100;
        end
        default: ;
      endcase
      if (w_fin) r_hash <= w_sum;
    end
  end

`ifdef SHA256_TARGET_CMP_EN
  logic [255:0] w_sum_rev;
  logic         r_hit;

  always_comb begin
    w_sum_rev = '0;
    for (int i = 0; i < 32; i++) w_sum_rev[8*i +: 8] = w_sum[8*(31-i) +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_hit <= 1'b0;
    else if (w_fin) r_hit <= (w_sum_rev <= target);
  end

  assign out_hit = r_hit;
`endif

endmodule

// File: tb/tb_sha256_iter_core.sv
// tb/tb_sha256_iter_core.sv - directed self-checking bench for sha256_iter_core
module tb_sha256_iter_core;

  localparam logic [255:0] IV_ST   = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
  localparam logic [511:0] ABC_BLK = {32'h00000018, 448'h0, 32'h61626380};
  localparam logic [255:0] H_ABC   = 256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
  localparam logic [255:0] H_ABC2  = 256'h3e6c6358_d5128cc0_05daed5a_5b2d606d_8d2da7cc_519ba6f6_2dd3729b_4f8b42c2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_state;
  logic [511:0] in_block;
  logic         in_dbl;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_hash;
  logic         busy;
  logic [255:0] target;
  logic         out_hit;

  logic         sw_valid;
  logic [3:0]   sw_ir, sw_ov, sw_busy, sw_hit;
  logic [255:0] sw_oh [4];

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sha256_iter_core #(.UNROLL(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_block(in_block), .in_dbl(in_dbl),
    .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash),
`ifdef SHA256_TARGET_CMP_EN
    .target(target), .out_hit(out_hit),
`endif
    .busy(busy)
  );

  sha256_iter_core #(.UNROLL(1)) u_u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[0]),
    .in_state(in_state), .in_block(in_block), .in_dbl(in_dbl),
    .out_valid(sw_ov[0]), .out_ready(1'b1), .out_hash(sw_oh[0]),
`ifdef SHA256_TARGET_CMP_EN
    .target(target), .out_hit(sw_hit[0]),
`endif
    .busy(sw_busy[0])
  );

  sha256_iter_core #(.UNROLL(2)) u_u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[1]),
    .in_state(in_state), .in_block(in_block), .in_dbl(in_dbl),
    .out_valid(sw_ov[1]), .out_ready(1'b1), .out_hash(sw_oh[1]),
`ifdef SHA256_TARGET_CMP_EN
    .target(target), .out_hit(sw_hit[1]),
`endif
    .busy(sw_busy[1])
  );

  sha256_iter_core #(.UNROLL(8)) u_u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[2]),
    .in_state(in_state), .in_block(in_block), .in_dbl(in_dbl),
    .out_valid(sw_ov[2]), .out_ready(1'b1), .out_hash(sw_oh[2]),
`ifdef SHA256_TARGET_CMP_EN
    .target(target), .out_hit(sw_hit[2]),
`endif
    .busy(sw_busy[2])
  );

  sha256_iter_core #(.UNROLL(64)) u_u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[3]),
    .in_state(in_state), .in_block(in_block), .in_dbl(in_dbl),
    .out_valid(sw_ov[3]), .out_ready(1'b1), .out_hash(sw_oh[3]),
`ifdef SHA256_TARGET_CMP_EN
    .target(target), .out_hit(sw_hit[3]),
`endif
    .busy(sw_busy[3])
  );

  // Presents one job for exactly one accept edge; returns at the negedge after it.
  task automatic start_job(input logic [255:0] st, input logic [511:0] blk, input logic dbl);
    @(negedge clk);
    in_state = st;
    in_block = blk;
    in_dbl   = dbl;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycles after the accept edge until out_valid is seen; -1 if it never comes.
  task automatic wait_out(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_hash !== '0)    begin bad++; $display("FAIL reset_out_hash got=%h exp=0", out_hash); end
  endtask

  task automatic test_single();
    int lat;
    out_ready = 1'b1;
    start_job(IV_ST, ABC_BLK, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_out(lat);
    total++; if (lat !== 17)       begin bad++; $display("FAIL single_latency got=%0d exp=17", lat); end
    total++; if (out_hash !== H_ABC) begin bad++; $display("FAIL single_hash got=%h exp=%h", out_hash, H_ABC); end
    @(negedge clk);
  endtask

  task automatic test_double();
    int lat;
    out_ready = 1'b1;
    start_job(IV_ST, ABC_BLK, 1'b1);
    wait_out(lat);
    total++; if (lat !== 34)          begin bad++; $display("FAIL dbl_latency got=%0d exp=34", lat); end
    total++; if (out_hash !== H_ABC2) begin bad++; $display("FAIL dbl_hash got=%h exp=%h", out_hash, H_ABC2); end
    @(negedge clk);
  endtask

  task automatic test_unroll_sweep();
    int           lat [4];
    logic [255:0] hv  [4];
    int           exp_lat [4];
    exp_lat = '{65, 33, 9, 2};
    for (int k = 0; k < 4; k++) begin
      lat[k] = -1;
      hv[k]  = '0;
    end
    @(negedge clk);
    in_state = IV_ST;
    in_block = ABC_BLK;
    in_dbl   = 1'b0;
    sw_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (sw_ov[k] && lat[k] < 0) begin
          lat[k] = c;
          hv[k]  = sw_oh[k];
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (lat[k] !== exp_lat[k]) begin bad++; $display("FAIL sweep_latency[%0d] got=%0d exp=%0d", k, lat[k], exp_lat[k]); end
      total++; if (hv[k] !== H_ABC)       begin bad++; $display("FAIL sweep_hash[%0d] got=%h exp=%h", k, hv[k], H_ABC); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    start_job(IV_ST, ABC_BLK, 1'b0);
    // junk job offered while busy: different block and dbl=1, must be ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_block = '0;
    in_dbl   = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    if (lat > 0) lat = lat + 4;
    total++; if (lat !== 17)         begin bad++; $display("FAIL bp_latency got=%0d exp=17", lat); end
    total++; if (out_hash !== H_ABC) begin bad++; $display("FAIL bp_hash got=%h exp=%h", out_hash, H_ABC); end
    // second job waits while output is stalled
    in_state = IV_ST;
    in_block = ABC_BLK;
    in_dbl   = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, out_valid); end
      total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_hold_in_ready c=%0d got=%b exp=0", c, in_ready); end
      total++; if (out_hash !== H_ABC) begin bad++; $display("FAIL bp_hold_hash c=%0d got=%h exp=%h", c, out_hash, H_ABC); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_after_xfer in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_second_accept busy=%b exp=1", busy); end
    wait_out(lat);
    total++; if (lat !== 34)          begin bad++; $display("FAIL bp_second_latency got=%0d exp=34", lat); end
    total++; if (out_hash !== H_ABC2) begin bad++; $display("FAIL bp_second_hash got=%h exp=%h", out_hash, H_ABC2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    start_job(IV_ST, ABC_BLK, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (out_hash !== '0)    begin bad++; $display("FAIL rst_mid_hash got=%h exp=0", out_hash); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
    end
    start_job(IV_ST, ABC_BLK, 1'b0);
    wait_out(lat);
    total++; if (lat !== 17)         begin bad++; $display("FAIL rst_mid_new_latency got=%0d exp=17", lat); end
    total++; if (out_hash !== H_ABC) begin bad++; $display("FAIL rst_mid_new_hash got=%h exp=%h", out_hash, H_ABC); end
    @(negedge clk);
  endtask

`ifdef SHA256_TARGET_CMP_EN
  task automatic test_target();
    int           lat;
    logic [255:0] rev;
    logic         exp_hit [3];
    logic [255:0] tgt [3];
    for (int i = 0; i < 32; i++) rev[8*i +: 8] = H_ABC2[8*(31-i) +: 8];
    tgt     = '{{256{1'b1}}, 256'h0, rev};
    exp_hit = '{1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      target = tgt[t];
      start_job(IV_ST, ABC_BLK, 1'b1);
      wait_out(lat);
      total++; if (out_hit !== exp_hit[t]) begin bad++; $display("FAIL target_hit[%0d] got=%b exp=%b", t, out_hit, exp_hit[t]); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_block  = '0;
    in_dbl    = 1'b0;
    out_ready = 1'b1;
    target    = '0;
    sw_valid  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_double();
    test_unroll_sweep();
    test_backpressure();
    test_reset_mid();
`ifdef SHA256_TARGET_CMP_EN
    test_target();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
